// File: rtl/rect_fill_writer.sv
// Rectangle fill producer: latches one fill command, clips it to the visible
// frame and streams one pixel write per handshake in raster order.
module rect_fill_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [15:0] cmd_color,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        program_valid,
    input  logic        program_ready,
    output logic [9:0]  program_x,
    output logic [9:0]  program_y,
    output logic [15:0] program_data
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLIP = 2'd1;
    localparam logic [1:0] S_DRAW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);

    logic [1:0]  state_q, state_d;
    logic [9:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [15:0] color_q, color_d;
    logic [10:0] x_end_q, x_end_d, y_end_q, y_end_d;
    logic [10:0] x_sum, y_sum, x_nxt, y_nxt;
    logic        empty;

    always_comb begin
        // 11-bit sums so origin + size can never wrap before clipping
        x_sum = {1'b0, x0_q} + {1'b0, w_q};
        y_sum = {1'b0, y0_q} + {1'b0, h_q};
        x_nxt = {1'b0, cur_x_q} + 11'd1;
        y_nxt = {1'b0, cur_y_q} + 11'd1;
        empty = (w_q == 10'd0) || (h_q == 10'd0) ||
                ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM);

        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    x0_d    = cmd_x;
                    y0_d    = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = S_CLIP;
                end
            end
            S_CLIP: begin
                x_end_d = (x_sum > H_LIM) ? H_LIM : x_sum;
                y_end_d = (y_sum > V_LIM) ? V_LIM : y_sum;
                if (empty) begin
                    state_d = S_DONE;
                end else begin
                    cur_x_d = x0_q;
                    cur_y_d = y0_q;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (program_ready) begin
                    if (x_nxt < x_end_q) begin
                        cur_x_d = cur_x_q + 10'd1;
                    end else begin
                        cur_x_d = x0_q;
                        if (y_nxt < y_end_q) cur_y_d = cur_y_q + 10'd1;
                        else                 state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
        end
    end

    assign cmd_busy      = (state_q != S_IDLE);
    assign cmd_done      = (state_q == S_DONE);
    assign program_valid = (state_q == S_DRAW);
    assign program_x     = cur_x_q;
    assign program_y     = cur_y_q;
    assign program_data  = color_q;
endmodule

// File: doc/rect_fill_writer.md
# rect_fill_writer

Write-side producer for the SRAM frame-buffer controller's program port. Accepts a single "fill rectangle" command (origin, size, 16-bit colour), clips it to the 640x480 visible frame, and emits one pixel write per cycle as (program_x, program_y, program_data) beats under a valid/ready handshake. It sits between game-logic draw requests and the frame buffer: the VGA side reads the buffer, and this block is the writer that fills it.

## Interface
- H_RES, 640, visible frame width in pixels
- V_RES, 480, visible frame height in pixels
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- cmd_start  input  1  command strobe; sampled only when cmd_busy=0
- cmd_x  input  10  rectangle origin x
- cmd_y  input  10  rectangle origin y
- cmd_w  input  10  rectangle width in pixels
- cmd_h  input  10  rectangle height in pixels
- cmd_color  input  16  fill colour (5-6-5 RGB, passed through unchanged)
- cmd_busy  output  1  high from the cycle after an accepted start until the cycle after cmd_done
- cmd_done  output  1  one-cycle pulse when the command completes
- program_valid  output  1  pixel beat present
- program_ready  input  1  controller accepts the beat this cycle
- program_x  output  10  pixel x
- program_y  output  10  pixel y
- program_data  output  16  pixel colour

## Operation
- States: IDLE, CLIP, DRAW, DONE.
- IDLE: cmd_start=1 latches cmd_* into internal registers and moves to CLIP. cmd_start while not in IDLE is ignored; the command is not queued.
- CLIP (1 cycle): x_end = min(cmd_x + cmd_w, H_RES), y_end = min(cmd_y + cmd_h, V_RES), summed in 11 bits so there is no wrap. The rectangle is empty if cmd_w=0, cmd_h=0, cmd_x>=H_RES or cmd_y>=V_RES. Empty goes to DONE; otherwise load cur_x=cmd_x, cur_y=cmd_y and go to DRAW.
- DRAW: program_valid=1, program_x=cur_x, program_y=cur_y, program_data=latched colour.
  - On valid&ready: if cur_x+1 < x_end then cur_x++.
  - Otherwise cur_x=cmd_x; if cur_y+1 < y_end then cur_y++, else go to DONE.
  - Raster order: row-major, left to right, top to bottom.
- DONE (1 cycle): cmd_done=1, then go to IDLE.
- cmd_busy = (state != IDLE).

## Timing
- Reset values (reset_n=0 at an edge): state=IDLE, cmd_busy=0, cmd_done=0, program_valid=0, program_x=0, program_y=0, program_data=0.
- Reset mid-command: all outputs return to reset values at the next edge, and the command is abandoned with no cmd_done.
- Start accepted at edge 0. CLIP occupies cycle 1. First program_valid appears in cycle 2.
- Throughput: one pixel per cycle while program_ready=1.
- Backpressure: while program_valid=1 and program_ready=0, program_x, program_y and program_data hold stable and valid stays high. Valid never drops in DRAW until the last beat is taken.
- cmd_done is asserted in the cycle after the last handshake. cmd_busy falls one cycle after that. The earliest next start is accepted in the cycle cmd_busy=0.
- Empty command: start at edge 0, cmd_done in cycle 2, and program_valid is never asserted.
- Total pixels emitted = (x_end - cmd_x) * (y_end - cmd_y). No beat ever has x >= H_RES or y >= V_RES.

## Test plan
- Basic fill:
  - Stimulus: start with x=10, y=20, w=3, h=2, color=16'hF800; program_ready held at 1.
  - Required: 6 beats in cycles 2-7, in order (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all with data F800. cmd_done in cycle 8.
- Backpressure:
  - Stimulus: same command, with program_ready toggling 1,0,0,1,...
  - Required: the same 6 beats in the same order, with no duplicates. Outputs stay stable on every stalled cycle.
- Clipping:
  - Stimulus: x=638, y=478, w=5, h=5.
  - Required: exactly 4 beats, (638,478) (639,478) (638,479) (639,479), then cmd_done.
- Empty commands:
  - Stimulus: w=0; then separately x=640.
  - Required: no program_valid; cmd_done in cycle 2 after the start; cmd_busy high in cycles 1-2.
- Start while busy and reset mid-draw:
  - Stimulus: a second cmd_start during DRAW; then reset_n=0 after the 3rd beat.
  - Required: the second start is ignored with no extra beats. After reset, program_valid=0, cmd_busy=0, and no cmd_done. A new command then starts normally.
